// File: rtl/transform_pkg.sv
// Shared constants, address field layout and load-FSM state type for the transform parameter bank.
package transform_pkg;

  localparam int REG_COUNT = 11;
  localparam int REG_WIDTH = 0;
  localparam int REG_DEPTH = 1;
  localparam int REG_T11   = 2;
  localparam int REG_T12   = 3;
  localparam int REG_T13   = 4;
  localparam int REG_T21   = 5;
  localparam int REG_T22   = 6;
  localparam int REG_T23   = 7;
  localparam int REG_T31   = 8;
  localparam int REG_T32   = 9;
  localparam int REG_T33   = 10;

  localparam int IDX_MSB  = 6;
  localparam int IDX_LSB  = 3;
  localparam int MODE_MSB = 2;
  localparam int MODE_LSB = 1;
  localparam int CAM_BIT  = 0;

  localparam int ADDR_W    = 7;
  localparam int RAM_DEPTH = 88;

  localparam logic [3:0] LAST_IDX = 4'(REG_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_COMMIT
  } load_state_e;

  function automatic logic idx_in_range(input logic [ADDR_W-1:0] addr);
    return addr[IDX_MSB:IDX_LSB] <= LAST_IDX;
  endfunction

endpackage

// File: rtl/transform_reg_ram.sv
// 88-entry parameter store: one write port, one registered read port, read-first on collision.
module transform_reg_ram
  import transform_pkg::*;
#(
  parameter int DATA_W = 25
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [RAM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Both ports update on the same edge, so a colliding read returns the old word.
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < 7'(RAM_DEPTH))) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (raddr_i < 7'(RAM_DEPTH)) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/transform_reg_bank.sv
// Frame-synchronous parameter bank: stages a mode/camera register set and commits it atomically.
// Optional readback port enabled by defining TRANSFORM_REG_READBACK_EN.
module transform_reg_bank
  import transform_pkg::*;
#(
  parameter int CAM_LINE  = 9,
  parameter int CAM_PIXEL = 10,
  parameter int DATA_W    = 25
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [DATA_W-1:0]    i_data,
  input  logic                 i_we,
  input  logic                 i_configured,
  input  logic                 i_frame_start,
  input  logic [1:0]           i_mode,
  input  logic                 i_cam,
`ifdef TRANSFORM_REG_READBACK_EN
  input  logic [ADDR_W-1:0]    i_rd_addr,
  input  logic                 i_rd_en,
  output logic [DATA_W-1:0]    o_rd_data,
  output logic                 o_rd_valid,
`endif
  output logic [CAM_PIXEL-1:0] o_width,
  output logic [CAM_LINE-1:0]  o_depth,
  output logic [DATA_W-1:0]    o_t11,
  output logic [DATA_W-1:0]    o_t12,
  output logic [DATA_W-1:0]    o_t13,
  output logic [DATA_W-1:0]    o_t21,
  output logic [DATA_W-1:0]    o_t22,
  output logic [DATA_W-1:0]    o_t23,
  output logic [DATA_W-1:0]    o_t31,
  output logic [DATA_W-1:0]    o_t32,
  output logic [DATA_W-1:0]    o_t33,
  output logic                 o_params_valid,
  output logic                 o_commit,
  output logic                 o_busy
);

  load_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic        pend_q, pend_d;
  logic        commit_en;
  logic        start_ok;

  logic              ret_valid_q;
  logic [3:0]        ret_idx_q;
  logic [DATA_W-1:0] stage_q [REG_COUNT];

  logic [CAM_PIXEL-1:0] width_q;
  logic [CAM_LINE-1:0]  depth_q;
  logic [DATA_W-1:0]    coef_q [REG_COUNT-2];
  logic                 commit_q;
  logic                 valid_q;

  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign start_ok = i_frame_start && i_configured;

  transform_reg_ram #(
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (i_we && idx_in_range(i_addr)),
    .waddr_i (i_addr),
    .wdata_i (i_data),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    pend_d    = pend_q;
    commit_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          sel_d   = {i_mode, i_cam};
        end
      end
      ST_LOAD: begin
        if (start_ok) pend_d = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (start_ok) pend_d = 1'b1;
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit_en = 1'b1;
        // A frame start held during the load chains straight into the next one.
        if (pend_q || start_ok) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          sel_d   = {i_mode, i_cam};
          pend_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      pend_q      <= 1'b0;
      ret_valid_q <= 1'b0;
      ret_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      pend_q      <= pend_d;
      ret_valid_q <= (state_q == ST_LOAD);
      ret_idx_q   <= cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (ret_valid_q) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (ret_idx_q == 4'(i)) stage_q[i] <= ram_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      width_q  <= '0;
      depth_q  <= '0;
      for (int i = 0; i < REG_COUNT - 2; i++) coef_q[i] <= '0;
      commit_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      commit_q <= commit_en;
      if (commit_en) begin
        width_q <= stage_q[REG_WIDTH][CAM_PIXEL-1:0];
        depth_q <= stage_q[REG_DEPTH][CAM_LINE-1:0];
        for (int i = 0; i < REG_COUNT - 2; i++) coef_q[i] <= stage_q[REG_T11 + i];
        valid_q <= 1'b1;
      end
    end
  end

  logic unused_stage_hi;
  assign unused_stage_hi = ^{stage_q[REG_WIDTH][DATA_W-1:CAM_PIXEL],
                             stage_q[REG_DEPTH][DATA_W-1:CAM_LINE]};

`ifdef TRANSFORM_REG_READBACK_EN
  logic              rb_hold_q, rb_hold_d;
  logic [ADDR_W-1:0] rb_addr_q, rb_addr_d;
  logic              rb_valid_q, rb_oob_q;
  logic              rb_serve, rb_idle;
  logic [ADDR_W-1:0] rb_req_addr;

  // The FSM owns the read port outside IDLE; requests made then wait for the port.
  always_comb begin
    rb_idle     = (state_q == ST_IDLE);
    rb_serve    = rb_idle && (rb_hold_q || i_rd_en);
    rb_req_addr = rb_hold_q ? rb_addr_q : i_rd_addr;
    rb_hold_d   = rb_hold_q;
    rb_addr_d   = rb_addr_q;
    if (rb_idle) begin
      rb_hold_d = rb_hold_q && i_rd_en;
      if (rb_hold_q && i_rd_en) rb_addr_d = i_rd_addr;
    end else if (i_rd_en) begin
      rb_hold_d = 1'b1;
      rb_addr_d = i_rd_addr;
    end
    ram_raddr = rb_idle ? rb_req_addr : {cnt_q, sel_q};
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      rb_hold_q  <= 1'b0;
      rb_addr_q  <= '0;
      rb_valid_q <= 1'b0;
      rb_oob_q   <= 1'b0;
    end else begin
      rb_hold_q  <= rb_hold_d;
      rb_addr_q  <= rb_addr_d;
      rb_valid_q <= rb_serve;
      rb_oob_q   <= !idx_in_range(rb_req_addr);
    end
  end

  assign o_rd_valid = rb_valid_q;
  assign o_rd_data  = (rb_valid_q && !rb_oob_q) ? ram_rdata : '0;
`else
  assign ram_raddr = {cnt_q, sel_q};
`endif

  assign o_width        = width_q;
  assign o_depth        = depth_q;
  assign o_t11          = coef_q[0];
  assign o_t12          = coef_q[1];
  assign o_t13          = coef_q[2];
  assign o_t21          = coef_q[3];
  assign o_t22          = coef_q[4];
  assign o_t23          = coef_q[5];
  assign o_t31          = coef_q[6];
  assign o_t32          = coef_q[7];
  assign o_t33          = coef_q[8];
  assign o_params_valid = valid_q;
  assign o_commit       = commit_q;
  assign o_busy         = (state_q != ST_IDLE);

endmodule
